display_share_arbiter: RTL
==========================

Name: display_share_arbiter

Overview:
- Shares the single 4-digit hex display controller between three requesters, e.g. a counter, a switch readout and a debug value.
- Arbitration is round-robin with a minimum dwell time, measured in ticks of the ~1 kHz clock-enable pulse.
- Outputs drive the display controller's dig1..dig4 inputs directly.
- Instantiated beside the display controller in each top level; it shares that controller's clk, reset and clock-enable tick.

Parameters:
DWELL, 500, minimum ownership time in tick pulses before another requester may take over; legal range 1..65535.
IDLE_PATTERN, 16'h0000, value shown on the display when nobody owns it.

Ports:
clk  input  1  100 MHz system clock
reset  input  1  asynchronous, active-high reset
tick  input  1  one-cycle enable pulse from the 1 kHz clock enable
req  input  3  req[i]=1: requester i wants the display (level, held while wanted)
val0  input  16  requester 0 value; [3:0] goes to dig1 (rightmost), [15:12] to dig4 (leftmost)
val1  input  16  requester 1 value, same packing
val2  input  16  requester 2 value, same packing
gnt  output  3  one-hot grant; 3'b000 when idle
busy  output  1  1 while any requester owns the display
owner  output  2  index of current owner; holds last owner while idle
dig1  output  4  rightmost nibble to display controller
dig2  output  4  second nibble
dig3  output  4  third nibble
dig4  output  4  leftmost nibble

Behaviour:
- Reset (async, active-high): state=IDLE, gnt=0, busy=0, owner=2 (so requester 0 wins first), dwell counter=0, {dig4,dig3,dig2,dig1}=IDLE_PATTERN. All outputs are registered.
- Round-robin search order from current owner o: o+1, o+2 (mod 3), then o itself.
- State IDLE:
  - If req != 0, grant the first asserted requester in search order.
  - Next cycle: gnt one-hot, busy=1, owner updated, dwell counter cleared, state=HOLD.
- State HOLD:
  - On each tick, increment the dwell counter.
  - A tick while counter==DWELL-1 moves to SHARE.
  - If the owner's req drops, release immediately, regardless of tick.
  - On release: if another req is set, grant the next in search order (owner excluded), clear the counter, stay in HOLD. Otherwise go to IDLE (gnt=0, busy=0, owner kept).
- State SHARE:
  - If the owner's req drops, apply the same release rule as HOLD.
  - If the owner still requests and any other req is set, rotate to the next asserted requester in search order, clear the counter, go to HOLD.
  - If the owner is the only requester, stay in SHARE.
- Grant change latency: a req change seen at clock edge n is reflected in gnt/owner at edge n+1, with no gap cycle between owners.
- Digit latency:
  - dig* = registered value of the current owner's val, sampled every cycle, so live values track with 1-cycle latency.
  - On a grant change, dig* shows the new owner's val one cycle after gnt changes.
  - In IDLE, dig* = IDLE_PATTERN one cycle after busy falls.
- Simultaneous events:
  - Owner drop in the same cycle as a tick: the drop wins; the tick is not counted.
  - A new requester rising in the same cycle the owner drops: that requester is eligible in the same search.
- Width rules: the dwell counter is 16 bits, compared against DWELL-1, and never wraps because it clears on grant.
- Invariants: gnt is never multi-hot; gnt[owner]==busy.
- Reset mid-ownership: all outputs return immediately to reset values; arbitration restarts from requester 0.

Test Plan:
- Reset then idle: reset=1, req=0 -> gnt=000, busy=0, owner=2, digits={0,0,0,0}. With IDLE_PATTERN=16'hABCD -> dig4..dig1 = A,B,C,D.
- Single requester: DWELL=4, req=001, val0=16'h1234 -> gnt=001 one cycle later; dig4..dig1 = 1,2,3,4 one cycle after that. val0 changes to 16'h5678 -> digits follow 1 cycle later.
- Dwell enforcement: owner 0 granted, req=011 from start, DWELL=4 -> gnt stays 001 through 3 ticks, SHARE entered on the 4th tick. Next cycle gnt=010, dig4..dig1 = digits of val1.
- Round-robin fairness: req=111 held, DWELL=2 -> grant sequence 001,010,100,001, with each change exactly one cycle after the 2nd tick of each ownership.
- Early release and collision: owner 1 in HOLD drops req in the same cycle as a tick while req2=1 -> gnt=100 next cycle; dwell counter=0, not incremented.
- Async reset mid-operation: assert reset between clock edges while gnt=010 -> gnt=000, busy=0, digits=IDLE_PATTERN without waiting for a clock edge. After release with req=110 -> first grant 010 (search starts at 0, and req0=0).

Source files
------------

// File: rtl/display_share_arbiter.sv
// Round-robin arbiter that shares one 4-digit hex display between three requesters.
// Each grant is held for at least DWELL ticks unless the owner lets go first.
module display_share_arbiter #(
    parameter int unsigned  DWELL        = 500,
    parameter logic [15:0]  IDLE_PATTERN = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [2:0]  req,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    input  logic [15:0] val2,
    output logic [2:0]  gnt,
    output logic        busy,
    output logic [1:0]  owner,
    output logic [3:0]  dig1,
    output logic [3:0]  dig2,
    output logic [3:0]  dig3,
    output logic [3:0]  dig4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        SHARE = 2'd2
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    state_t      state;
    logic [15:0] dwell_cnt;

    logic [3:0]  req_x;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic        owner_req;
    logic        other_found;
    logic [1:0]  pick_other;
    logic [1:0]  pick_any;
    logic        do_grant;
    logic        go_idle;
    logic [1:0]  grant_idx;
    logic [15:0] owner_val;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] one_hot(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Search order from the current owner o is o+1, o+2, then o itself.
    always_comb begin
        req_x       = {1'b0, req};
        cand1       = next_idx(owner);
        cand2       = next_idx(cand1);
        owner_req   = req_x[owner];
        other_found = req_x[cand1] | req_x[cand2];
        pick_other  = req_x[cand1] ? cand1 : cand2;
        pick_any    = other_found ? pick_other : owner;
    end

    // A dropping owner always wins over a tick in the same cycle.
    always_comb begin
        do_grant  = 1'b0;
        go_idle   = 1'b0;
        grant_idx = pick_other;
        case (state)
            IDLE: begin
                do_grant  = |req;
                grant_idx = pick_any;
            end
            HOLD, SHARE: begin
                if (!owner_req) begin
                    do_grant = other_found;
                    go_idle  = !other_found;
                end else if (state == SHARE) begin
                    do_grant = other_found;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    always_comb begin
        case (owner)
            2'd0:    owner_val = val0;
            2'd1:    owner_val = val1;
            default: owner_val = val2;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            gnt                    <= 3'b000;
            busy                   <= 1'b0;
            owner                  <= 2'd2;
            dwell_cnt              <= 16'd0;
            {dig4, dig3, dig2, dig1} <= IDLE_PATTERN;
        end else begin
            {dig4, dig3, dig2, dig1} <= busy ? owner_val : IDLE_PATTERN;
            if (do_grant) begin
                state     <= HOLD;
                gnt       <= one_hot(grant_idx);
                busy      <= 1'b1;
                owner     <= grant_idx;
                dwell_cnt <= 16'd0;
            end else if (go_idle) begin
                state     <= IDLE;
                gnt       <= 3'b000;
                busy      <= 1'b0;
            end else if (state == HOLD && tick) begin
                dwell_cnt <= dwell_cnt + 16'd1;
                if (dwell_cnt == DWELL_LAST) begin
                    state <= SHARE;
                end
            end
        end
    end

endmodule
